// File: rtl/fib_ram_reader.sv
// Read-side walker for the odd-Fibonacci RAM: steps through the stored entries
// and shows each one in decimal, with its index, on a 4-digit multiplexed display.
module fib_ram_reader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 50_000_000,
  parameter int SCAN_CYC = 100_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] count,
  input  logic              loop,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [3:0]        anodes,
  output logic [7:0]        segments
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] SHOW = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] disp_q;
  logic              vld_p0;
  logic [HOLD_W-1:0] hold_q;
  logic [SCAN_W-1:0] scan_q;
  logic [1:0]        dig_q;
  logic [11:0]       bcd;

  // Double-dabble: 8-bit binary to three BCD digits {H,T,O}.
  function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
    logic [19:0] sr;
    sr = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sr[11:8]  > 4'd4) sr[11:8]  = sr[11:8]  + 4'd3;
      if (sr[15:12] > 4'd4) sr[15:12] = sr[15:12] + 4'd3;
      if (sr[19:16] > 4'd4) sr[19:16] = sr[19:16] + 4'd3;
      sr = sr << 1;
    end
    return sr[19:8];
  endfunction

  // Active-low {a,b,c,d,e,f,g,dp} hex glyphs, dp off.
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 8'h03;  4'h1: glyph = 8'h9F;  4'h2: glyph = 8'h25;  4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h49;  4'h6: glyph = 8'h41;  4'h7: glyph = 8'h1F;
      4'h8: glyph = 8'h01;  4'h9: glyph = 8'h09;  4'hA: glyph = 8'h11;  4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;  4'hD: glyph = 8'h85;  4'hE: glyph = 8'h61;  default: glyph = 8'h71;
    endcase
  endfunction

  assign last_addr = cnt_q - 1'b1;
  assign busy      = (state == ADDR) || (state == LOAD) || (state == SHOW);
  assign done      = (state == DONE);

  // Read sequencer: address settle, capture, then hold for the display period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rd_addr <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      vld_p0  <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (count != '0) begin
              cnt_q   <= count;
              rd_addr <= '0;
              state   <= ADDR;
            end else begin
              state <= DONE;
            end
          end
        end
        ADDR: state <= LOAD;
        LOAD: begin
          disp_q <= rd_data;
          vld_p0 <= 1'b1;
          hold_q <= '0;
          state  <= SHOW;
        end
        SHOW: begin
          if (hold_q == HOLD_LAST) begin
            if (rd_addr != last_addr) begin
              rd_addr <= rd_addr + 1'b1;
              state   <= ADDR;
            end else if (loop) begin
              rd_addr <= '0;
              state   <= ADDR;
            end else begin
              state <= DONE;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scan; parked at digit 0 while idle so each pass starts aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q <= '0;
      dig_q  <= '0;
    end else if (state == IDLE) begin
      scan_q <= '0;
      dig_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      dig_q  <= dig_q + 2'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // Nothing is shown until the first value has been captured (e.g. a zero-length pass).
  always_comb begin
    bcd      = bin2bcd(8'(disp_q));
    anodes   = 4'b1111;
    segments = 8'hFF;
    if (state != IDLE) begin
      anodes = ~(4'b0001 << dig_q);
      if (vld_p0) begin
        case (dig_q)
          2'd0: segments = glyph(bcd[3:0]);
          2'd1: if (bcd[11:4] != 8'd0) segments = glyph(bcd[7:4]);
          2'd2: if (bcd[11:8] != 4'd0) segments = glyph(bcd[11:8]);
          default: segments = glyph(4'(rd_addr));
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fib_ram_reader.sv
// Scoreboard bench for fib_ram_reader with a short hold/scan period and an async-read RAM model.
module tb_fib_ram_reader;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] count;
  logic       loop;
  logic [7:0] rd_data;
  logic [3:0] rd_addr;
  logic       busy;
  logic       done;
  logic [3:0] anodes;
  logic [7:0] segments;

  logic [7:0] ram [16];
  assign rd_data = ram[rd_addr];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] val;
  } ent_t;
  ent_t sb[$];

  int total = 0;
  int bad   = 0;

  fib_ram_reader #(.ADDR_W(4), .DATA_W(8), .HOLD_CYC(4), .SCAN_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .count(count), .loop(loop),
    .rd_data(rd_data), .rd_addr(rd_addr), .busy(busy), .done(done),
    .anodes(anodes), .segments(segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_ent(input int a);
    ent_t e;
    e.addr = 4'(a);
    e.val  = ram[a];
    sb.push_back(e);
  endtask

  // Entry monitor: an entry starts when busy rises or rd_addr moves; its value lands two edges later.
  initial begin
    int   mcyc;
    int   last_start;
    int   pend;
    logic busy_prev;
    logic [3:0] addr_prev;
    ent_t e;
    mcyc = 0; last_start = 0; pend = 0; busy_prev = 1'b0; addr_prev = '0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (!reset_n) begin
        pend = 0; busy_prev = 1'b0; addr_prev = '0;
      end else begin
        if (anodes != 4'b1111) chk("busy_xor_done", 32'(busy ^ done), 1);
        if (busy && (!busy_prev || rd_addr != addr_prev)) begin
          if (busy_prev) chk("entry_period", mcyc - last_start, 6);
          last_start = mcyc;
          pend = 2;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            if (sb.size() == 0) begin
              chk("sb_underflow", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("entry_addr", rd_addr, e.addr);
              chk("entry_val", dut.disp_q, e.val);
            end
          end
        end
        busy_prev = busy;
        addr_prev = rd_addr;
      end
    end
  end

  // Pulses start, then waits for done; exp_n counts negedges from the start edge to done.
  task automatic run_pass(input logic [3:0] cnt, input int exp_n, input bit noise);
    int n;
    count = cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_addr", rd_addr, 0);
    n = 1;
    while (!done && n < 200) begin
      if (noise) begin
        if (n < 20) begin
          start = n[0];
          count = 4'hF;
        end else begin
          start = 1'b0;
        end
      end
      if (n == 40) loop = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("pass_len", n, exp_n);
    chk("end_addr", rd_addr, 32'(cnt - 4'd1));
    chk("end_busy", busy, 0);
  endtask

  // Locks onto the first cycle of digit 0, then checks one full scan (2 cycles per digit).
  task automatic disp_check(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [3:0] prev;
    logic [3:0] pat [4];
    logic [7:0] seg [4];
    bit         hit;
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    seg[0] = s0; seg[1] = s1; seg[2] = s2; seg[3] = s3;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      prev = anodes;
      @(negedge clk);
      if (anodes == 4'b1110 && prev != 4'b1110) hit = 1'b1;
    end
    chk("scan_sync", 32'(hit), 1);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      chk("scan_anodes", anodes, pat[j/2]);
      chk("scan_segments", segments, seg[j/2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'd0;
    ram[0] = 8'd1;  ram[1] = 8'd1;  ram[2] = 8'd3;  ram[3] = 8'd5;  ram[4] = 8'd13;
    ram[5] = 8'd21; ram[6] = 8'd55; ram[7] = 8'd89; ram[8] = 8'd233;
    start = 1'b0; count = 4'd0; loop = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_anodes", anodes, 4'b1111);
    chk("rst_segments", segments, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Full pass without looping, then the decoded display of entry 8 (233).
    for (int a = 0; a < 9; a++) push_ent(a);
    run_pass(4'd9, 55, 1'b0);
    disp_check(8'h0D, 8'h0D, 8'h25, 8'h01);

    // Restart from DONE with start/count noise during the pass; ends on 5 at index 3.
    for (int a = 0; a < 4; a++) push_ent(a);
    run_pass(4'd4, 25, 1'b1);
    disp_check(8'h49, 8'hFF, 8'hFF, 8'h0D);

    // Restart with a two-entry pass.
    for (int a = 0; a < 2; a++) push_ent(a);
    run_pass(4'd2, 13, 1'b0);

    // Looping three entries; loop drops before the third wrap so it stops after entry 2.
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < 3; a++) push_ent(a);
    loop = 1'b1;
    run_pass(4'd3, 55, 1'b0);

    // Asynchronous reset in the SHOW phase of entry 1.
    push_ent(0);
    push_ent(1);
    count = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_addr", rd_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_anodes", anodes, 4'b1111);
    chk("midrst_segments", segments, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_anodes", anodes, 4'b1111);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Zero-length pass: straight to DONE with a blank display, and start again stays there.
    count = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    disp_check(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_redone", done, 1);
    chk("zero_rebusy", busy, 0);

    @(negedge clk);
    chk("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_ram_reader.md
# fib_ram_reader

Read-side companion to the odd-Fibonacci writer datapath. After the writer has filled the single-port RAM, this block walks addresses 0..count-1 and captures each stored 8-bit value. It shows each value in decimal on the 4-digit multiplexed seven-segment display, with the entry index on the leftmost digit. It drives the RAM address while the writer is idle; the top level muxes `rd_addr` onto the RAM address input.

## Interface

**Parameters**
- `ADDR_W`, default 4: RAM address width; matches the writer counter width.
- `DATA_W`, default 8: RAM word width.
- `HOLD_CYC`, default 50_000_000: clock cycles each entry stays displayed (≥1).
- `SCAN_CYC`, default 100_000: clock cycles per digit during display scanning (≥1).

**Ports**
- `clk`, in, 1: the single clock; every flop is rising-edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level, sampled in IDLE and DONE; begins a read pass.
- `count`, in, ADDR_W: number of valid RAM entries; latched when `start` is accepted.
- `loop`, in, 1: 1 means wrap to entry 0 after the last entry; 0 means stop in DONE.
- `rd_data`, in, DATA_W: RAM `data_out`.
- `rd_addr`, out, ADDR_W: RAM read address (registered).
- `busy`, out, 1: high in ADDR, LOAD and SHOW.
- `done`, out, 1: high in DONE.
- `anodes`, out, 4: digit enables, active-low; `anodes[0]` is the rightmost digit.
- `segments`, out, 8: active-low, ordered {a,b,c,d,e,f,g,dp}; dp is always 1 (off).

## Operation

**States:** IDLE, ADDR, LOAD, SHOW, DONE.
- **IDLE**
  - With `start`=1 and `count`≠0: latch `count` into `cnt_q`, set `rd_addr`=0, go to ADDR.
  - With `start`=1 and `count`=0: go to DONE; the display stays blank.
- **ADDR:** one settle cycle with `rd_addr` stable. Go to LOAD.
- **LOAD:** capture `rd_data` into `disp_q`, clear the hold timer. Go to SHOW.
- **SHOW:** the hold timer counts 0..HOLD_CYC-1. On the terminal count:
  - If `rd_addr`≠`cnt_q`-1: increment `rd_addr`, go to ADDR.
  - If `rd_addr`=`cnt_q`-1 and `loop`=1: set `rd_addr`=0, go to ADDR.
  - If `rd_addr`=`cnt_q`-1 and `loop`=0: go to DONE.
- **DONE:** hold `rd_addr` and `disp_q`; the last value stays displayed.
  - `start`=1 with `count`≠0: restart exactly as from IDLE, re-latching `count`.
  - `start`=1 with `count`=0: stay in DONE.
- **Ignored inputs:** `start` is ignored in ADDR, LOAD and SHOW. Changes to `count` after it is latched are ignored.

**Display**
- Convert `disp_q` (0..255) to BCD digits H, T, O (shift-add-3 or equivalent; purely combinational from `disp_q`).
- Digit 0 shows O.
- Digit 1 shows T; it is blank if H=0 and T=0.
- Digit 2 shows H; it is blank if H=0.
- Digit 3 shows `rd_addr[3:0]` as a hex glyph, 0-F.
- In IDLE, all anodes are 1.
- The scan counter counts 0..SCAN_CYC-1. On its terminal count, the digit select advances 0→1→2→3→0.
- Exactly one anode is low at a time outside IDLE. A blanked digit has its anode low and `segments`=8'hFF.
- **Glyphs:** 0=8'h03, 1=8'h9F, 2=8'h25, 3=8'h0D, 5=8'h49, blank=8'hFF.

**Reset:** an asynchronous assertion at any point returns the block to IDLE immediately, mid-pass included.

## Timing

- **Reset values:** state IDLE; `rd_addr`=0; `busy`=0; `done`=0; `anodes`=4'b1111; `segments`=8'hFF; `disp_q`=0; `cnt_q`=0; hold timer, scan counter and digit select all 0.
- **Start sequence:** `start` high at rising edge k in IDLE gives:
  - edge k: ADDR, `rd_addr`=0, `busy`=1.
  - edge k+1: LOAD.
  - edge k+2: `disp_q` valid, SHOW.
- **Read latency:** `rd_data` is sampled at the end of LOAD, 2 cycles after `rd_addr` changes. This covers both asynchronous-read and 1-cycle registered-read RAM.
- **Per-entry period:** exactly HOLD_CYC+2 cycles.
- **End of pass:** on the SHOW→DONE edge, `busy` falls and `done` rises on the same edge; there is no cycle with both high or both low.
- **Segment/anode alignment:** `segments` and `anodes` change on the same edge.

## Test plan

1. **Reset:** assert `reset_n`=0 mid-SHOW → outputs return to reset values within the same cycle, asynchronously; after release, state is IDLE and `anodes`=4'b1111.
2. **Full pass, no loop:** HOLD_CYC=4, SCAN_CYC=2, RAM holds 1,1,3,5,13,21,55,89,233, `count`=9, `loop`=0, pulse `start`.
   - `rd_addr` steps 0..8 every 6 cycles.
   - `disp_q` sequence matches the RAM contents.
   - `done` rises after the SHOW of entry 8; `rd_addr` holds at 8.
3. **Display decode:**
   - `disp_q`=233 → digits 2,3,3 on anodes 2,1,0.
   - `disp_q`=5 → digit 0 = 8'h49, digits 1 and 2 = 8'hFF.
   - Index digit shows 8 (entry 8).
   - Each anode pattern lasts 2 cycles, in the order 1110, 1101, 1011, 0111.
4. **Loop:** `count`=3, `loop`=1 → `rd_addr` sequence 0,1,2,0,1…; `done` never rises. Drop `loop` to 0 → stops in DONE after entry 2.
5. **Ignored and zero inputs:**
   - Toggle `start` and change `count` to 15 during SHOW → no effect on the pass.
   - `count`=0 with `start` → DONE directly, display blank, `busy` never high.
6. **Restart:** `start` in DONE with `count`=2 → new pass from `rd_addr`=0, `busy`=1 one edge later.
